// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-I-subset core.
// Holds the opcode and funct encodings, the halt instruction word,
// the ALU operation enum and a sign-extension helper.
package cpu_pkg;

   // Primary opcodes (insn[31:26])
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_SLTIU = 6'd11;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_XORI  = 6'd14;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   // R-type funct codes (insn[5:0])
   localparam logic [5:0] FN_SLL  = 6'd0;
   localparam logic [5:0] FN_SRL  = 6'd2;
   localparam logic [5:0] FN_SRA  = 6'd3;
   localparam logic [5:0] FN_SLLV = 6'd4;
   localparam logic [5:0] FN_SRLV = 6'd6;
   localparam logic [5:0] FN_SRAV = 6'd7;
   localparam logic [5:0] FN_JR   = 6'd8;
   localparam logic [5:0] FN_JALR = 6'd9;
   localparam logic [5:0] FN_ADD  = 6'd32;
   localparam logic [5:0] FN_ADDU = 6'd33;
   localparam logic [5:0] FN_SUB  = 6'd34;
   localparam logic [5:0] FN_SUBU = 6'd35;
   localparam logic [5:0] FN_AND  = 6'd36;
   localparam logic [5:0] FN_OR   = 6'd37;
   localparam logic [5:0] FN_XOR  = 6'd38;
   localparam logic [5:0] FN_NOR  = 6'd39;
   localparam logic [5:0] FN_SLT  = 6'd42;
   localparam logic [5:0] FN_SLTU = 6'd43;

   localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_PASSB
   } alu_op_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: NREGS x 32 bits, register 0 reads as zero.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low clear of all registers
//   i_we, i_waddr, i_wdata write port (writes to register 0 are dropped)
//   i_raddr1 / o_rdata1    combinational read port 1 (rs)
//   i_raddr2 / o_rdata2    combinational read port 2 (rt)
module cpu_regfile #(
   parameter int NREGS = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_we,
   input  logic [$clog2(NREGS)-1:0] i_waddr,
   input  logic [31:0]              i_wdata,
   input  logic [$clog2(NREGS)-1:0] i_raddr1,
   output logic [31:0]              o_rdata1,
   input  logic [$clog2(NREGS)-1:0] i_raddr2,
   output logic [31:0]              o_rdata2
);

   logic [31:0] r_regs [NREGS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == '0) ? 32'd0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? 32'd0 : r_regs[i_raddr2];

endmodule

// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-I-subset core. One instruction completes per
// un-stalled rising clock edge; no pipeline, no delay slots, no exceptions.
// Ports:
//   clock, reset        clock; asynchronous active-low reset
//   stall               1 = hold PC, registers and Halt; suppresses stores
//   Halt                registered, set by the all-ones halt instruction
//   CRead0 / CWrite0    data-port load / store strobes
//   CAddr0              data byte address (rs + sext(imm16))
//   CReadData0          combinational big-endian load word
//   CWriteData0         store data (rt)
//   CAddr1              instruction fetch address (PC)
//   CReadData1          combinational instruction word
module cpu
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   output logic        Halt,
   output logic        CRead0,
   output logic        CWrite0,
   output logic [31:0] CAddr0,
   input  logic [31:0] CReadData0,
   output logic [31:0] CWriteData0,
   output logic [31:0] CAddr1,
   input  logic [31:0] CReadData1
);

   logic [31:0] r_pc;
   logic        r_halt;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [15:0] w_imm16;
   logic [25:0] w_imm26;
   logic [31:0] w_pc4, w_sext, w_zext, w_br_tgt, w_j_tgt;
   logic [31:0] w_rs_val, w_rt_val;

   alu_op_t     w_alu_op;
   logic [31:0] w_alu_b, w_alu_y, w_wdata, w_npc;
   logic [4:0]  w_sh, w_waddr;
   logic        w_we, w_link, w_is_lw, w_is_sw, w_is_halt, w_commit;

   assign w_op     = CReadData1[31:26];
   assign w_rs     = CReadData1[25:21];
   assign w_rt     = CReadData1[20:16];
   assign w_rd     = CReadData1[15:11];
   assign w_shamt  = CReadData1[10:6];
   assign w_funct  = CReadData1[5:0];
   assign w_imm16  = CReadData1[15:0];
   assign w_imm26  = CReadData1[25:0];

   assign w_pc4    = r_pc + 32'd4;
   assign w_sext   = sext16(w_imm16);
   assign w_zext   = {16'd0, w_imm16};
   assign w_br_tgt = w_pc4 + {w_sext[29:0], 2'b00};
   assign w_j_tgt  = {w_pc4[31:28], w_imm26, 2'b00};

   // State only advances when not stalled and not halted.
   assign w_commit = !stall && !r_halt;

   cpu_regfile #(.NREGS(NREGS)) u_regfile (
      .i_clk    (clock),
      .i_rst_n  (reset),
      .i_we     (w_we && w_commit),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wdata),
      .i_raddr1 (w_rs),
      .o_rdata1 (w_rs_val),
      .i_raddr2 (w_rt),
      .o_rdata2 (w_rt_val)
   );

   // Decode
   always_comb begin
      w_alu_op  = ALU_ADD;
      w_alu_b   = w_rt_val;
      w_sh      = w_shamt;
      w_we      = 1'b0;
      w_waddr   = w_rd;
      w_link    = 1'b0;
      w_is_lw   = 1'b0;
      w_is_sw   = 1'b0;
      w_npc     = w_pc4;
      w_is_halt = (CReadData1 == HALT_INSN);
      if (!w_is_halt) begin
         case (w_op)
            OP_RTYPE: begin
               w_we = 1'b1;
               case (w_funct)
                  FN_SLL:          w_alu_op = ALU_SLL;
                  FN_SRL:          w_alu_op = ALU_SRL;
                  FN_SRA:          w_alu_op = ALU_SRA;
                  FN_SLLV: begin w_alu_op = ALU_SLL; w_sh = w_rs_val[4:0]; end
                  FN_SRLV: begin w_alu_op = ALU_SRL; w_sh = w_rs_val[4:0]; end
                  FN_SRAV: begin w_alu_op = ALU_SRA; w_sh = w_rs_val[4:0]; end
                  FN_JR:   begin w_we = 1'b0; w_npc = w_rs_val; end
                  FN_JALR: begin w_link = 1'b1; w_npc = w_rs_val; end
                  FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
                  FN_SUB, FN_SUBU: w_alu_op = ALU_SUB;
                  FN_AND:          w_alu_op = ALU_AND;
                  FN_OR:           w_alu_op = ALU_OR;
                  FN_XOR:          w_alu_op = ALU_XOR;
                  FN_NOR:          w_alu_op = ALU_NOR;
                  FN_SLT:          w_alu_op = ALU_SLT;
                  FN_SLTU:         w_alu_op = ALU_SLTU;
                  default:         w_we = 1'b0;
               endcase
            end
            OP_J:   w_npc = w_j_tgt;
            OP_JAL: begin
               w_we    = 1'b1;
               w_waddr = 5'd31;
               w_link  = 1'b1;
               w_npc   = w_j_tgt;
            end
            OP_BEQ: if (w_rs_val == w_rt_val) w_npc = w_br_tgt;
            OP_BNE: if (w_rs_val != w_rt_val) w_npc = w_br_tgt;
            OP_ADDI, OP_ADDIU: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_sext;
            end
            OP_SLTI: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_sext; w_alu_op = ALU_SLT;
            end
            // Immediate is sign-extended, then compared as unsigned.
            OP_SLTIU: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_sext; w_alu_op = ALU_SLTU;
            end
            OP_ANDI: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_zext; w_alu_op = ALU_AND;
            end
            OP_ORI: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_zext; w_alu_op = ALU_OR;
            end
            OP_XORI: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_zext; w_alu_op = ALU_XOR;
            end
            OP_LUI: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = {w_imm16, 16'd0};
               w_alu_op = ALU_PASSB;
            end
            OP_LW: begin
               w_we = 1'b1; w_waddr = w_rt; w_alu_b = w_sext; w_is_lw = 1'b1;
            end
            OP_SW: begin
               w_alu_b = w_sext; w_is_sw = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ALU; shift operations act on the rt operand (w_alu_b)
   always_comb begin
      case (w_alu_op)
         ALU_ADD:   w_alu_y = w_rs_val + w_alu_b;
         ALU_SUB:   w_alu_y = w_rs_val - w_alu_b;
         ALU_AND:   w_alu_y = w_rs_val & w_alu_b;
         ALU_OR:    w_alu_y = w_rs_val | w_alu_b;
         ALU_XOR:   w_alu_y = w_rs_val ^ w_alu_b;
         ALU_NOR:   w_alu_y = ~(w_rs_val | w_alu_b);
         ALU_SLT:   w_alu_y = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
         ALU_SLTU:  w_alu_y = {31'd0, w_rs_val < w_alu_b};
         ALU_SLL:   w_alu_y = w_alu_b << w_sh;
         ALU_SRL:   w_alu_y = w_alu_b >> w_sh;
         ALU_SRA:   w_alu_y = $unsigned($signed(w_alu_b) >>> w_sh);
         ALU_PASSB: w_alu_y = w_alu_b;
         default:   w_alu_y = w_rs_val + w_alu_b;
      endcase
   end

   assign w_wdata = w_link ? w_pc4 : (w_is_lw ? CReadData0 : w_alu_y);

   // PC and halt flag; the halt instruction freezes the PC on itself.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc   <= RESET_PC;
         r_halt <= 1'b0;
      end else if (w_commit) begin
         if (w_is_halt) r_halt <= 1'b1;
         else           r_pc   <= w_npc;
      end
   end

   // Strobes are gated by reset directly so they drop without waiting for an edge.
   assign CRead0      = w_is_lw && !r_halt && reset;
   assign CWrite0     = w_is_sw && w_commit && reset;
   assign CAddr0      = w_alu_y;
   assign CWriteData0 = w_rt_val;
   assign CAddr1      = r_pc;
   assign Halt        = r_halt;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        Halt, CRead0, CWrite0;
   logic [31:0] CAddr0, CReadData0, CWriteData0, CAddr1, CReadData1;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int wr_base;

   always #5 clk = ~clk;

   cpu dut (
      .clock       (clk),
      .reset       (reset),
      .stall       (stall),
      .Halt        (Halt),
      .CRead0      (CRead0),
      .CWrite0     (CWrite0),
      .CAddr0      (CAddr0),
      .CReadData0  (CReadData0),
      .CWriteData0 (CWriteData0),
      .CAddr1      (CAddr1),
      .CReadData1  (CReadData1)
   );

   always @(posedge clk) if (CWrite0) wr_count++;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] ld;
      logic [31:0] pc;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] enc_r(input int rs, rt, rd, sh, fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(input int op, rs, rt, imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int op, tgt);
      return {6'(op), 26'(tgt)};
   endfunction

   function automatic vec_t mk(input logic [31:0] insn, ld, pc, input logic rd, wr,
                               input logic [31:0] addr, wdata);
      vec_t v;
      v.insn = insn; v.ld = ld; v.pc = pc; v.rd = rd; v.wr = wr;
      v.addr = addr; v.wdata = wdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge: apply the instruction, check outputs, advance one cycle.
   task automatic step(input vec_t v, input string tag);
      CReadData1 = v.insn;
      CReadData0 = v.ld;
      #1;
      chk({tag, " pc"}, CAddr1, v.pc);
      chk({tag, " rd"}, {31'd0, CRead0}, {31'd0, v.rd});
      chk({tag, " wr"}, {31'd0, CWrite0}, {31'd0, v.wr});
      chk({tag, " halt"}, {31'd0, Halt}, 32'd0);
      if (v.rd || v.wr) chk({tag, " addr"}, CAddr0, v.addr);
      if (v.wr) chk({tag, " wdata"}, CWriteData0, v.wdata);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // sw probes: sw rX,0(r0) exposes register X on CWriteData0
      vecs.push_back(mk(enc_i(13,0,1,16'h00FF), 0, 32'h00, 0,0, 0,0));          // ori r1
      vecs.push_back(mk(enc_i(15,0,2,16'h8000), 0, 32'h04, 0,0, 0,0));          // lui r2
      vecs.push_back(mk(enc_r(1,2,3,0,33),      0, 32'h08, 0,0, 0,0));          // addu r3
      vecs.push_back(mk(enc_i(43,0,3,0),        0, 32'h0C, 0,1, 0,32'h800000FF));
      vecs.push_back(mk(enc_r(0,2,4,4,3),       0, 32'h10, 0,0, 0,0));          // sra r4
      vecs.push_back(mk(enc_r(1,2,5,0,43),      0, 32'h14, 0,0, 0,0));          // sltu r5
      vecs.push_back(mk(enc_r(1,2,6,0,42),      0, 32'h18, 0,0, 0,0));          // slt r6
      vecs.push_back(mk(enc_i(43,0,4,0),        0, 32'h1C, 0,1, 0,32'hF8000000));
      vecs.push_back(mk(enc_j(3,12),            0, 32'h20, 0,0, 0,0));          // jal 0x30
      vecs.push_back(mk(enc_i(43,0,5,0),        0, 32'h30, 0,1, 0,32'd1));
      vecs.push_back(mk(enc_i(43,0,6,4),        0, 32'h34, 0,1, 4,32'd0));
      vecs.push_back(mk(enc_i(43,0,31,0),       0, 32'h38, 0,1, 0,32'h24));
      vecs.push_back(mk(enc_r(31,0,0,0,8),      0, 32'h3C, 0,0, 0,0));          // jr r31
      vecs.push_back(mk(enc_i(15,0,7,16'h0008), 0, 32'h24, 0,0, 0,0));          // lui r7
      vecs.push_back(mk(enc_i(15,0,8,16'h1234), 0, 32'h28, 0,0, 0,0));          // lui r8
      vecs.push_back(mk(enc_i(13,8,8,16'h5678), 0, 32'h2C, 0,0, 0,0));          // ori r8
      vecs.push_back(mk(enc_i(43,7,8,4),        0, 32'h30, 0,1, 32'h80004,32'h12345678));
      vecs.push_back(mk(enc_i(35,7,9,4), 32'h12345678, 32'h34, 1,0, 32'h80004,0)); // lw r9
      vecs.push_back(mk(enc_i(43,0,9,0),        0, 32'h38, 0,1, 0,32'h12345678));
      vecs.push_back(mk(enc_i(4,9,8,1),         0, 32'h3C, 0,0, 0,0));          // beq taken
      vecs.push_back(mk(enc_i(5,9,8,5),         0, 32'h44, 0,0, 0,0));          // bne not taken
      vecs.push_back(mk(enc_i(8,0,0,5),         0, 32'h48, 0,0, 0,0));          // addi r0
      vecs.push_back(mk(enc_i(43,0,0,0),        0, 32'h4C, 0,1, 0,32'd0));
      vecs.push_back(mk(enc_r(1,2,10,0,6),      0, 32'h50, 0,0, 0,0));          // srlv r10
      vecs.push_back(mk(enc_i(10,2,11,1),       0, 32'h54, 0,0, 0,0));          // slti r11
      vecs.push_back(mk(enc_i(11,1,12,16'hFFFF),0, 32'h58, 0,0, 0,0));          // sltiu r12
      vecs.push_back(mk(enc_i(43,0,10,0),       0, 32'h5C, 0,1, 0,32'd1));
      vecs.push_back(mk(enc_r(1,2,13,0,34),     0, 32'h60, 0,0, 0,0));          // sub r13
      vecs.push_back(mk(enc_i(14,1,14,16'h8000),0, 32'h64, 0,0, 0,0));          // xori r14
      vecs.push_back(mk(enc_r(1,0,15,0,39),     0, 32'h68, 0,0, 0,0));          // nor r15
      vecs.push_back(mk(enc_i(43,0,11,0),       0, 32'h6C, 0,1, 0,32'd1));
      vecs.push_back(mk(enc_i(43,0,12,0),       0, 32'h70, 0,1, 0,32'd1));
      vecs.push_back(mk(enc_i(43,0,13,0),       0, 32'h74, 0,1, 0,32'h800000FF));
      vecs.push_back(mk(enc_i(43,0,14,0),       0, 32'h78, 0,1, 0,32'h000080FF));
      vecs.push_back(mk(enc_i(43,0,15,0),       0, 32'h7C, 0,1, 0,32'hFFFFFF00));
      vecs.push_back(mk(enc_j(2,32'h40),        0, 32'h80, 0,0, 0,0));          // j 0x100
      vecs.push_back(mk(32'h7C000000,           0, 32'h100,0,0, 0,0));          // unknown op
      vecs.push_back(mk(enc_r(7,0,16,0,9),      0, 32'h104,0,0, 0,0));          // jalr r16,r7
      vecs.push_back(mk(enc_i(43,0,16,0),       0, 32'h80000,0,1, 0,32'h108));
      vecs.push_back(mk(enc_i(8,0,17,16'hFFFC), 0, 32'h80004,0,0, 0,0));        // addi r17,-4
      vecs.push_back(mk(enc_i(43,0,17,8),       0, 32'h80008,0,1, 8,32'hFFFFFFFC));
      vecs.push_back(mk(enc_i(5,17,0,16'hFFFC), 0, 32'h8000C,0,0, 0,0));        // bne back
      vecs.push_back(mk(enc_i(43,0,3,0),        0, 32'h80000,0,1, 0,32'h800000FF));

      // Reset state
      reset = 1'b0; stall = 1'b0; CReadData0 = 0;
      CReadData1 = enc_i(35,0,1,0);
      #3;
      chk("rst pc", CAddr1, 32'd0);
      chk("rst halt", {31'd0, Halt}, 32'd0);
      chk("rst rd", {31'd0, CRead0}, 32'd0);
      CReadData1 = enc_i(43,0,5,0);
      #1;
      chk("rst wr", {31'd0, CWrite0}, 32'd0);
      chk("rst regs", CWriteData0, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

      // Stall three cycles across a store
      CReadData1 = enc_i(43,7,8,0);
      stall = 1'b1;
      wr_base = wr_count;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall%0d pc", i), CAddr1, 32'h80004);
         chk($sformatf("stall%0d wr", i), {31'd0, CWrite0}, 32'd0);
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      chk("unstall wr", {31'd0, CWrite0}, 32'd1);
      chk("unstall addr", CAddr0, 32'h80000);
      chk("unstall wdata", CWriteData0, 32'h12345678);
      @(negedge clk);

      // Halt and freeze
      CReadData1 = 32'hFFFF_FFFF;
      #1;
      chk("pre-halt pc", CAddr1, 32'h80008);
      chk("store count", 32'(wr_count - wr_base), 32'd1);
      chk("pre-halt halt", {31'd0, Halt}, 32'd0);
      @(negedge clk);
      CReadData1 = enc_i(9,0,3,1);
      #1;
      chk("halt set", {31'd0, Halt}, 32'd1);
      chk("halt pc", CAddr1, 32'h80008);
      @(negedge clk);
      CReadData1 = enc_j(2,0);
      #1;
      chk("halted pc", CAddr1, 32'h80008);
      @(negedge clk);
      CReadData1 = enc_i(43,0,3,0);
      #1;
      chk("halted pc2", CAddr1, 32'h80008);
      chk("halted wr", {31'd0, CWrite0}, 32'd0);
      chk("halted r3", CWriteData0, 32'h800000FF);
      chk("halted halt", {31'd0, Halt}, 32'd1);

      // Asynchronous reset between clock edges
      #1 reset = 1'b0;
      #1;
      chk("async halt", {31'd0, Halt}, 32'd0);
      chk("async pc", CAddr1, 32'd0);
      chk("async wr", {31'd0, CWrite0}, 32'd0);
      chk("async regs", CWriteData0, 32'd0);
      CReadData1 = enc_i(35,0,1,0);
      #1;
      chk("async rd", {31'd0, CRead0}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(mk(enc_i(43,0,3,0), 0, 32'h0, 0,1, 0,32'd0), "post-rst sw r3");
      step(mk(enc_i(13,0,1,16'h00FF), 0, 32'h4, 0,0, 0,0), "post-rst ori");
      step(mk(enc_i(43,0,1,0), 0, 32'h8, 0,1, 0,32'h000000FF), "post-rst sw r1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
